connect_mode_ctrl: RTL
======================

# connect_mode_ctrl

Controller that owns the compression-enable select of the channel connect block. On a mode request it stalls new address issue, drains every outstanding AXI transaction on the XHB side, toggles the enable only when the bus is quiet, then releases the stall. It sits between the system configuration register and the connect block's enable input. Observed handshakes come from the muxed XHB-side channels.

## Interface
Parameters:
- `OST_W`, default 6: outstanding-counter width; 63 transactions max per direction.
- `SETTLE_CYC`, default 2: cycles the stall is held after the enable toggles.
- `TMO_W`, default 10: drain-timeout counter width; timeout fires after 2^TMO_W−1 drain cycles.

Ports:
- `CLK_i`, in, 1: clock.
- `RSTN_i`, in, 1: reset; asynchronous assert, active-low.
- `MODE_REQ_i`, in, 1: requested mode, level; 1 = compressed path.
- `ARVALID_i` / `ARREADY_i`, in, 1 each: XHB-side AR handshake.
- `AWVALID_i` / `AWREADY_i`, in, 1 each: XHB-side AW handshake.
- `WVALID_i`, in, 1: XHB-side W valid.
- `RVALID_i` / `RREADY_i` / `RLAST_i`, in, 1 each: XHB-side R handshake.
- `BVALID_i` / `BREADY_i`, in, 1 each: XHB-side B handshake.
- `ERR_CLR_i`, in, 1: clears all sticky error flags.
- `ENABLE_o`, out, 1: enable to the connect block; reset 0.
- `STALL_o`, out, 1: upstream must gate new ARVALID/AWVALID; reset 0.
- `BUSY_o`, out, 1: state ≠ RUN; reset 0.
- `RD_OST_o`, out, OST_W: outstanding reads; reset 0.
- `WR_OST_o`, out, OST_W: outstanding writes; reset 0.
- `ERR_TMO_o` / `ERR_OVF_o` / `ERR_UNF_o`, out, 1 each: sticky error flags; reset 0.

## Operation
- Read counter: +1 on AR handshake (ARVALID&ARREADY). −1 on last R beat (RVALID&RREADY&RLAST).
- Write counter: +1 on AW handshake. −1 on B handshake.
- Increment and decrement in the same cycle leave the counter unchanged.
- At all-ones, an increment saturates the counter and sets ERR_OVF_o.
- At zero, a decrement holds the counter at 0 and sets ERR_UNF_o.
- Upstream never issues W before its AW. A W beat alone therefore never creates an untracked transaction.
- FSM:
  - RUN → DRAIN when MODE_REQ_i ≠ ENABLE_o.
  - DRAIN → RUN (abort) when MODE_REQ_i == ENABLE_o again.
  - DRAIN → SWITCH when quiet. Quiet = RD_OST == 0, WR_OST == 0, ARVALID_i = 0, AWVALID_i = 0, WVALID_i = 0, all in the same cycle.
  - SWITCH lasts 1 cycle and toggles ENABLE_o, then → SETTLE.
  - SETTLE counts SETTLE_CYC cycles, then → RUN.
- STALL_o = 1 in DRAIN, SWITCH and SETTLE. It is a registered output.
- Timeout counter runs only in DRAIN and clears on DRAIN exit.
  - On reaching all-ones it sets ERR_TMO_o. The FSM keeps waiting and never forces the switch.
- ERR_CLR_i clears the sticky flags.
  - If a flag's set condition occurs in the same cycle, set wins.
- A request change during SWITCH or SETTLE is ignored until RUN. It is then re-evaluated.
- Reset mid-operation: ENABLE_o = 0, counters 0, FSM in RUN, flags cleared. Any in-flight transactions are lost to tracking.

## Timing
- MODE_REQ_i change at cycle t: STALL_o and BUSY_o go high at t+1 (state DRAIN).
- Quiet first observed at cycle q: SWITCH at q+1, and ENABLE_o toggles at q+2.
  - STALL_o falls at q+2+SETTLE_CYC.
  - Minimum request-to-release latency with an idle bus: 3+SETTLE_CYC cycles.
- Handshakes in the cycle STALL_o rises are counted normally and must drain.
- Counter outputs reflect handshakes one cycle after they occur.
- ENABLE_o never changes in a cycle where either counter is non-zero.

## Structure
- Shared package `connect_pkg`:
  - state enum `conn_state_e`: RUN, DRAIN, SWITCH, SETTLE.
  - default constants OST_W, SETTLE_CYC, TMO_W.
- Sub-module `connect_ost_cnt`: saturating up/down counter with overflow and underflow pulses. Instantiated twice, once for reads and once for writes.
- Top level contains the FSM, settle and timeout counters, and the sticky flags.

## Test plan
- Idle bus; MODE_REQ_i 0→1 at cycle 10. Expect:
  - STALL_o = 1 at cycle 11.
  - ENABLE_o = 1 at cycle 13.
  - STALL_o = 0 at cycle 15 (SETTLE_CYC = 2).
- Issue 3 ARs (4-beat bursts) and 2 AWs, then request a switch. Expect:
  - ENABLE_o stays 0 until the third RLAST and second B complete.
  - ENABLE_o toggles 2 cycles after the quiet cycle.
- Simultaneous AR handshake and RLAST with RD_OST = 5 → RD_OST stays 5.
- Request 0→1, then back to 0 after 4 DRAIN cycles with RD_OST = 2 → returns to RUN, STALL_o drops, ENABLE_o never toggles.
- Hold RVALID low with RD_OST = 1, TMO_W = 4. Expect:
  - ERR_TMO_o set after 15 DRAIN cycles.
  - After RLAST, the switch completes.
  - ERR_CLR_i then clears the flag.
- Assert RSTN_i during SETTLE; also B handshake at WR_OST = 0. Expect:
  - Reset: all outputs return to reset values immediately.
  - B at zero: ERR_UNF_o = 1 and WR_OST stays 0.

Source files
------------

// File: rtl/connect_pkg.sv
// Shared types and default constants for the connect-block mode controller.
package connect_pkg;

  localparam int unsigned DEF_OST_W      = 6;
  localparam int unsigned DEF_SETTLE_CYC = 2;
  localparam int unsigned DEF_TMO_W      = 10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } conn_state_e;

endpackage

// File: rtl/connect_ost_cnt.sv
// Saturating outstanding-transaction counter with overflow/underflow pulses.
module connect_ost_cnt
  import connect_pkg::*;
#(
  parameter int unsigned W = DEF_OST_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_c,
  output logic         unf_c
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: simultaneous inc/dec cancel; saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_c = 1'b1;
      else                  cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) unf_c = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/connect_mode_ctrl.sv
// Compression-enable owner: drains the XHB side before toggling ENABLE_o.
module connect_mode_ctrl
  import connect_pkg::*;
#(
  parameter int unsigned OST_W      = DEF_OST_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned TMO_W      = DEF_TMO_W
) (
  input  logic             CLK_i,
  input  logic             RSTN_i,
  input  logic             MODE_REQ_i,
  input  logic             ARVALID_i,
  input  logic             ARREADY_i,
  input  logic             AWVALID_i,
  input  logic             AWREADY_i,
  input  logic             WVALID_i,
  input  logic             RVALID_i,
  input  logic             RREADY_i,
  input  logic             RLAST_i,
  input  logic             BVALID_i,
  input  logic             BREADY_i,
  input  logic             ERR_CLR_i,
  output logic             ENABLE_o,
  output logic             STALL_o,
  output logic             BUSY_o,
  output logic [OST_W-1:0] RD_OST_o,
  output logic [OST_W-1:0] WR_OST_o,
  output logic             ERR_TMO_o,
  output logic             ERR_OVF_o,
  output logic             ERR_UNF_o
);

  localparam int unsigned      SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_PRE = TMO_MAX - TMO_W'(1);

  conn_state_e      state_q, state_d;
  logic             enable_q, enable_d;
  logic             stall_q, stall_d;
  logic             busy_q, busy_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic [OST_W-1:0] rd_ost, wr_ost;
  logic             rd_ovf_c, rd_unf_c, wr_ovf_c, wr_unf_c;
  logic             tmo_hit_c;

  wire ar_hs_c  = ARVALID_i & ARREADY_i;
  wire aw_hs_c  = AWVALID_i & AWREADY_i;
  wire r_done_c = RVALID_i & RREADY_i & RLAST_i;
  wire b_hs_c   = BVALID_i & BREADY_i;
  wire quiet_c  = (rd_ost == '0) && (wr_ost == '0) && !ARVALID_i && !AWVALID_i && !WVALID_i;
  wire settle_last_c = (32'(settle_q) + 32'd1) >= SETTLE_CYC;

  connect_ost_cnt #(.W(OST_W)) u_rd_cnt (
    .clk   (CLK_i),
    .rst_n (RSTN_i),
    .inc_i (ar_hs_c),
    .dec_i (r_done_c),
    .cnt_o (rd_ost),
    .ovf_c (rd_ovf_c),
    .unf_c (rd_unf_c)
  );

  connect_ost_cnt #(.W(OST_W)) u_wr_cnt (
    .clk   (CLK_i),
    .rst_n (RSTN_i),
    .inc_i (aw_hs_c),
    .dec_i (b_hs_c),
    .cnt_o (wr_ost),
    .ovf_c (wr_ovf_c),
    .unf_c (wr_unf_c)
  );

  // Mode FSM, settle/timeout counters and sticky error flags (set beats clear).
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    settle_d  = settle_q;
    tmo_d     = '0;
    tmo_hit_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (MODE_REQ_i != enable_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (MODE_REQ_i == enable_q) begin
          state_d = ST_RUN;
        end else if (quiet_c) begin
          state_d = ST_SWITCH;
        end else begin
          tmo_d     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
          tmo_hit_c = (tmo_q == TMO_PRE);
        end
      end
      ST_SWITCH: begin
        enable_d = ~enable_q;
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_last_c) state_d = ST_RUN;
        else               settle_d = settle_q + SET_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
    stall_d   = (state_d != ST_RUN);
    busy_d    = (state_d != ST_RUN);
    err_tmo_d = tmo_hit_c | (err_tmo_q & ~ERR_CLR_i);
    err_ovf_d = rd_ovf_c | wr_ovf_c | (err_ovf_q & ~ERR_CLR_i);
    err_unf_d = rd_unf_c | wr_unf_c | (err_unf_q & ~ERR_CLR_i);
  end

  // Control and flag registers.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      state_q   <= ST_RUN;
      enable_q  <= 1'b0;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      settle_q  <= '0;
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign ENABLE_o  = enable_q;
  assign STALL_o   = stall_q;
  assign BUSY_o    = busy_q;
  assign RD_OST_o  = rd_ost;
  assign WR_OST_o  = wr_ost;
  assign ERR_TMO_o = err_tmo_q;
  assign ERR_OVF_o = err_ovf_q;
  assign ERR_UNF_o = err_unf_q;

endmodule
